// File: rtl/ctrl.sv
// ctrl: multi-cycle Moore control unit for the MIPS datapath.
// Walks each instruction through FETCH, DECODE and one to three execution
// states. Outputs are combinational from the current state, op/funct and
// the ALU zero flag, and are all forced low while rst is asserted.
module ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       PCWr,
  output logic       IRWr,
  output logic [2:0] NpcSel,
  output logic       RegWr,
  output logic [1:0] RegDst,
  output logic [1:0] WdSel,
  output logic       ALUSrc,
  output logic [2:0] ALUOp,
  output logic [1:0] ExtOp,
  output logic       MemWr,
  output logic [3:0] state_o
);

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXE    = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9
  } state_t;

  state_t state_q, state_d;

  logic is_rtype, is_r_alu, is_jr, is_i_alu, is_mem, is_jump;
  logic       exe_alusrc;
  logic [2:0] exe_aluop;
  logic [1:0] exe_extop;

  assign state_o = state_q;

  // Instruction class decode from the registered instruction word
  always_comb begin
    is_rtype = (op == OP_RTYPE);
    is_r_alu = is_rtype && ((funct == FN_ADDU) || (funct == FN_SUBU) ||
                            (funct == FN_SLT));
    is_jr    = is_rtype && (funct == FN_JR);
    is_i_alu = (op == OP_ADDIU) || (op == OP_ORI) || (op == OP_LUI);
    is_mem   = (op == OP_LW) || (op == OP_SW);
    is_jump  = (op == OP_J) || (op == OP_JAL) || is_jr;
  end

  // ALU operand/operation selection shared by EXE and ALUWB so the ALU
  // result stays stable through the write-back cycle
  always_comb begin
    exe_alusrc = 1'b0;
    exe_aluop  = 3'b000;
    exe_extop  = 2'b00;
    if (is_rtype) begin
      unique case (funct)
        FN_SUBU: exe_aluop = 3'b001;
        FN_SLT:  exe_aluop = 3'b011;
        default: exe_aluop = 3'b000;
      endcase
    end else begin
      exe_alusrc = 1'b1;
      unique case (op)
        OP_ORI: begin exe_aluop = 3'b010; exe_extop = 2'b00; end
        OP_LUI: begin exe_aluop = 3'b100; exe_extop = 2'b10; end
        default: begin exe_aluop = 3'b000; exe_extop = 2'b01; end
      endcase
    end
  end

  // Next-state selection
  always_comb begin
    state_d = S_FETCH;
    unique case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (is_mem)                     state_d = S_MEMADR;
        else if (is_r_alu || is_i_alu)  state_d = S_EXE;
        else if (op == OP_BEQ)          state_d = S_BRANCH;
        else if (is_jump)               state_d = S_JUMP;
        else                            state_d = S_FETCH;
      end
      S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXE:    state_d = S_ALUWB;
      default:  state_d = S_FETCH;
    endcase
  end

  // State register; async reset parks the machine in FETCH
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  // Moore output decode; everything held low while in reset so no PC/IR
  // or architectural write can happen until reset is released
  always_comb begin
    PCWr   = 1'b0;
    IRWr   = 1'b0;
    NpcSel = 3'b000;
    RegWr  = 1'b0;
    RegDst = 2'b00;
    WdSel  = 2'b00;
    ALUSrc = 1'b0;
    ALUOp  = 3'b000;
    ExtOp  = 2'b00;
    MemWr  = 1'b0;
    if (rst) begin
      unique case (state_q)
        S_FETCH: begin
          IRWr = 1'b1;
          PCWr = 1'b1;
        end
        S_MEMADR: begin
          ALUSrc = 1'b1;
          ExtOp  = 2'b01;
        end
        S_MEMWB: begin
          RegWr = 1'b1;
          WdSel = 2'b01;
        end
        S_MEMWR: MemWr = 1'b1;
        S_EXE: begin
          ALUSrc = exe_alusrc;
          ALUOp  = exe_aluop;
          ExtOp  = exe_extop;
        end
        S_ALUWB: begin
          ALUSrc = exe_alusrc;
          ALUOp  = exe_aluop;
          ExtOp  = exe_extop;
          RegWr  = 1'b1;
          RegDst = is_rtype ? 2'b01 : 2'b00;
        end
        S_BRANCH: begin
          ALUOp  = 3'b001;
          NpcSel = 3'b001;
          PCWr   = zero;
        end
        S_JUMP: begin
          PCWr = 1'b1;
          if (is_jr) begin
            NpcSel = 3'b011;
          end else begin
            NpcSel = 3'b010;
            if (op == OP_JAL) begin
              RegWr  = 1'b1;
              RegDst = 2'b10;
              WdSel  = 2'b10;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
